instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Builds 16-bit CPU instruction words from field-level requests and writes them sequentially into instruction memory.
//  It is the producer side of the control-unit decoder; bench and boot loader use it to preload programs.
//  Field-level valid/ready input; single-port IMEM write side; sticky error reporting.
// PARAMETERS
//  ADDR_W  8    IMEM word-address width
//  DEPTH   256  max words per program; must be <= 2**ADDR_W
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       1-cycle pulse; begin a program at base_addr
//  base_addr   in   ADDR_W  first IMEM address
//  in_valid    in   1       request valid
//  in_ready    out  1       request accepted when in_valid & in_ready
//  in_op       in   4       opcode: 0 R, 1 lw, 2 sw, 3 addi, 4 beq, 5 bne, 6 j
//  in_rs       in   4       source/base register
//  in_rt       in   4       second register
//  in_funct    in   4       R-type function: 0 add, 1 sub, 2 sll, 3 and
//  in_imm      in   12      I-type offset (signed) or J-type target
//  in_last     in   1       final instruction of the program
//  imem_we     out  1       IMEM write strobe
//  imem_addr   out  ADDR_W  IMEM address
//  imem_wdata  out  16      encoded word
//  imem_rdata  in   16      IMEM read data (1-cycle synchronous); used only with verify
//  count       out  ADDR_W+1  words written this program
//  busy        out  1       not IDLE
//  done        out  1       1-cycle pulse after the last write
//  illegal     out  1       1-cycle pulse, rejected request
//  err         out  1       sticky; cleared by start
// BEHAVIOUR
//  Encoding:
//   - R: {op, rs, rt, funct}
//   - I (1-5): {op, rs, rt, imm[3:0]}
//   - J: {op, imm[11:0]}
//  Legality; an illegal request is consumed, not written, and not counted:
//   - op > 6 is illegal.
//   - R with funct > 3 is illegal.
//   - I-type in_imm must be the sign-extension of imm[3:0] (-8..7).
//  FSM states: IDLE, ACCEPT, WRITE, DONE.
//   - IDLE: on start, ptr <= base_addr, count <= 0, err <= 0, then go to ACCEPT. start is ignored in other states.
//   - ACCEPT: in_ready = (count != DEPTH). A legal handshake registers the word and goes to WRITE.
//     An illegal handshake pulses illegal, sets err, stays in ACCEPT; if in_last is set it goes to DONE.
//   - WRITE: imem_we=1 for exactly 1 cycle with addr=ptr. Then ptr++ (wraps mod 2**ADDR_W) and count++.
//     Next state is DONE if the request carried in_last or count reaches DEPTH, otherwise ACCEPT.
//   - DONE: pulse done for 1 cycle, then go to IDLE.
//  Timing and boundaries:
//   - Latency: handshake in cycle N produces imem_we in cycle N+1. Throughput is 1 word per 2 cycles.
//   - Full: count==DEPTH drops in_ready and forces DONE. An overflow request is never accepted.
//   - Asserting rst_n low at any point returns the FSM to IDLE and aborts any pending write.
//  Reset values:
//   - in_ready, imem_we, busy, done, illegal, err, count, imem_addr, imem_wdata are all 0.
// CONFIGURATION
//  INSTR_ENC_VERIFY_EN defined:
//   - WRITE is followed by VREAD (addr held, we=0) and then VCMP.
//   - VCMP compares imem_rdata with the written word; on mismatch it sets err and pulses illegal.
//   - Throughput is 1 word per 4 cycles.
//  INSTR_ENC_VERIFY_EN undefined: no verify states; imem_rdata is ignored.
// STRUCTURE
//  Package instr_enc_pkg holds:
//   - opcode localparams OP_R..OP_J
//   - funct localparams FN_ADD..FN_AND
//   - field bit positions, state encoding
//  Sub-module instr_field_packer: combinational encode plus legality check. The FSM, pointer and counters live in the top.
// TESTING
//  start base=0x10; addi rs=1 rt=2 imm=5 -> imem_we cycle+1, addr 0x10, wdata 0x3125.
//  R op=0 rs=3 rt=4 funct=1; then j imm=0x0AB last -> 0x0341 @0x10, 0x60AB @0x11, done, count=2.
//  Edge cases -> illegal pulse, err=1, nothing written, count unchanged:
//   - beq imm=0xFF7 (-9)
//   - op=7
//   - R funct=5
//  DEPTH=4, 5 back-to-back requests -> 4 writes, done, in_ready stays 0 for the 5th.
//  Reset low during WRITE -> imem_we=0 same cycle, busy=0, count=0.
//  VERIFY_EN with the bench corrupting rdata -> err=1 after VCMP; done still pulses.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared opcodes, function codes, field positions and FSM encoding for the instruction encoder.
package instr_enc_pkg;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_J    = 4'd6;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_SLL = 4'd2;
  localparam logic [3:0] FN_AND = 4'd3;

  localparam int OP_LSB = 12;
  localparam int RS_LSB = 8;
  localparam int RT_LSB = 4;
  localparam int FN_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_VREAD  = 3'd4,
    S_VCMP   = 3'd5
  } state_t;

  function automatic logic is_itype(input logic [3:0] op);
    return (op >= OP_LW) && (op <= OP_BNE);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational instruction packing and legality check for one field-level request.
module instr_field_packer
  import instr_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [3:0]  rs,
  input  logic [3:0]  rt,
  input  logic [3:0]  funct,
  input  logic [11:0] imm,
  output logic [15:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    word[OP_LSB +: 4] = op;
    if (op == OP_R) begin
      word[RS_LSB +: 4] = rs;
      word[RT_LSB +: 4] = rt;
      word[FN_LSB +: 4] = funct;
      legal = (funct <= FN_AND);
    end else if (is_itype(op)) begin
      word[RS_LSB +: 4] = rs;
      word[RT_LSB +: 4] = rt;
      word[3:0]         = imm[3:0];
      // only a 4-bit offset fits, so the upper bits must be pure sign extension
      legal = (imm[11:4] == {8{imm[3]}});
    end else if (op == OP_J) begin
      word[11:0] = imm;
      legal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential IMEM program writer: accepts field requests, packs them and writes words from base_addr.
// Optional read-back verify after each write when INSTR_ENC_VERIFY_EN is defined.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_ACCEPT | in_ready high, waiting for a request
// S_WRITE  | imem_we high for one cycle at ptr
// S_VREAD  | verify only: address held, read issued
// S_VCMP   | verify only: compare read data with written word
// S_DONE   | done pulse, back to idle
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rt,
  input  logic [3:0]        in_funct,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  input  logic [15:0]       imem_rdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              last_q;
  logic [15:0]       enc_word;
  logic              enc_legal;
  logic [ADDR_W:0]   count_inc;
  logic              hs;

  instr_field_packer u_packer (
    .op    (in_op),
    .rs    (in_rs),
    .rt    (in_rt),
    .funct (in_funct),
    .imm   (in_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign hs        = in_valid & in_ready;
  assign count_inc = count + (ADDR_W+1)'(1);
  assign imem_addr = ptr;

`ifndef INSTR_ENC_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^imem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      count      <= '0;
      last_q     <= 1'b0;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr      <= base_addr;
            count    <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (hs) begin
            if (enc_legal) begin
              imem_we    <= 1'b1;
              imem_wdata <= enc_word;
              last_q     <= in_last;
              in_ready   <= 1'b0;
              state      <= S_WRITE;
            end else begin
              illegal <= 1'b1;
              err     <= 1'b1;
              if (in_last) begin
                in_ready <= 1'b0;
                done     <= 1'b1;
                state    <= S_DONE;
              end
            end
          end
        end
        S_WRITE: begin
`ifdef INSTR_ENC_VERIFY_EN
          state <= S_VREAD;
        end
        S_VREAD: state <= S_VCMP;
        S_VCMP: begin
          if (imem_rdata != imem_wdata) begin
            err     <= 1'b1;
            illegal <= 1'b1;
          end
`endif
          // advance after the write (or after its verify)
          ptr   <= ptr + ADDR_W'(1);
          count <= count_inc;
          if (last_q || (count_inc == DEPTH_C)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= S_ACCEPT;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus random programs against a field-level model.
module tb_instr_encoder;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op, in_rs, in_rt, in_funct;
  logic [11:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [15:0]       imem_rdata;
  logic [ADDR_W:0]   count;
  logic              busy, done, illegal, err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ill_cnt = 0;
  logic [23:0] wq[$];
  logic [15:0] mem [256];
  logic        corrupt = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .count(count), .busy(busy), .done(done),
    .illegal(illegal), .err(err)
  );

  // synchronous IMEM model; corrupt flips a bit on the read path
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    imem_rdata <= mem[imem_addr] ^ (corrupt ? 16'h0100 : 16'h0000);
  end

  always @(negedge clk) begin
    if (imem_we) wq.push_back({imem_addr, imem_wdata});
    if (done) done_cnt++;
    if (illegal) ill_cnt++;
  end

  function automatic bit ref_legal(int op, int funct, int imm);
    int simm;
    simm = (imm >= 2048) ? imm - 4096 : imm;
    if (op > 6) return 1'b0;
    if (op == 0) return funct <= 3;
    if (op == 6) return 1'b1;
    return (simm >= -8) && (simm <= 7);
  endfunction

  function automatic int ref_word(int op, int rs, int rt, int funct, int imm);
    if (op == 0) return op * 4096 + rs * 256 + rt * 16 + funct;
    if (op == 6) return op * 4096 + imm;
    return op * 4096 + rs * 256 + rt * 16 + (imm % 16);
  endfunction

  task automatic do_start(input int b);
    @(negedge clk);
    base_addr = 8'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int op, input int rs, input int rt, input int funct,
                      input int imm, input bit last);
    bit ok;
    in_op = 4'(op); in_rs = 4'(rs); in_rt = 4'(rt); in_funct = 4'(funct);
    in_imm = 12'(imm); in_last = last; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_handshake: in_ready got 0 want 1 (op %0d)", op);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_funct = '0; in_imm = '0; in_last = 1'b0;
    #1;
    checks++;
    if ({in_ready, imem_we, busy, done, illegal, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000", {in_ready, imem_we, busy, done, illegal, err});
    end
    checks++;
    if ({count, imem_addr, imem_wdata} !== 33'b0) begin
      errors++;
      $display("FAIL reset_data: count %h addr %h wdata %h want all 0", count, imem_addr, imem_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int d0;
    wq.delete();
    d0 = done_cnt;
    do_start(8'h10);
    send(3, 1, 2, 0, 5, 1'b1);
    checks++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h10, 16'h3125}) begin
      errors++;
      $display("FAIL addi_latency: we %b addr %h wdata %h want 1 10 3125", imem_we, imem_addr, imem_wdata);
    end
    wait_idle("addi");
    checks++;
    if (count !== 9'd1 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL addi_done: count %0d done %0d want 1 1", count, done_cnt - d0);
    end
    wq.delete();
    d0 = done_cnt;
    do_start(8'h10);
    send(0, 3, 4, 1, 0, 1'b0);
    send(6, 0, 0, 0, 12'h0AB, 1'b1);
    wait_idle("rj");
    checks++;
    if (wq.size() != 2 || wq[0] !== {8'h10, 16'h0341} || wq[1] !== {8'h11, 16'h60AB}) begin
      errors++;
      $display("FAIL rj_writes: got %0d writes first %h want 2 writes 100341 1160ab",
               wq.size(), (wq.size() > 0) ? wq[0] : 24'h0);
    end
    checks++;
    if (count !== 9'd2 || done_cnt != d0 + 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL rj_status: count %0d done %0d err %b want 2 1 0", count, done_cnt - d0, err);
    end
  endtask

  task automatic test_illegal;
    int i0;
    wq.delete();
    i0 = ill_cnt;
    do_start(8'h20);
    send(4, 1, 1, 0, 12'hFF7, 1'b0);
    checks++;
    if ({illegal, imem_we, err} !== 3'b101 || count !== 9'd0) begin
      errors++;
      $display("FAIL beq_range: illegal %b we %b err %b count %0d want 1 0 1 0", illegal, imem_we, err, count);
    end
    send(7, 1, 1, 0, 0, 1'b0);
    send(0, 1, 1, 5, 0, 1'b0);
    checks++;
    if (count !== 9'd0 || wq.size() != 0) begin
      errors++;
      $display("FAIL illegal_nowrite: count %0d writes %0d want 0 0", count, wq.size());
    end
    send(3, 2, 3, 0, 12'hFFF, 1'b1);
    wait_idle("illegal");
    checks++;
    if (ill_cnt != i0 + 3 || err !== 1'b1 || count !== 9'd1 || wq.size() != 1) begin
      errors++;
      $display("FAIL illegal_summary: pulses %0d err %b count %0d writes %0d want 3 1 1 1",
               ill_cnt - i0, err, count, wq.size());
    end
  endtask

  task automatic test_full;
    int d0;
    bit seen;
    wq.delete();
    d0 = done_cnt;
    do_start(8'hFE);
    for (int i = 0; i < 4; i++) send(1, i, i + 1, 0, i, 1'b0);
    in_op = 4'd3; in_valid = 1'b1; in_last = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) seen = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL full_ready: in_ready got 1 want 0 for fifth request");
    end
    wait_idle("full");
    checks++;
    if (wq.size() != 4 || count !== 9'd4 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL full_status: writes %0d count %0d done %0d want 4 4 1", wq.size(), count, done_cnt - d0);
    end
    checks++;
    if (wq.size() == 4 && (wq[2][23:16] !== 8'h00 || wq[3][23:16] !== 8'h01)) begin
      errors++;
      $display("FAIL full_wrap: addr %h %h want 00 01", wq[2][23:16], wq[3][23:16]);
    end
  endtask

  task automatic test_random;
    for (int p = 0; p < 30; p++) begin
      int base, n, wrote, ills, d0, i0, bad;
      int op, rs, rt, fn, imm;
      bit last, ended;
      logic [23:0] exp[$];
      exp.delete(); wq.delete();
      base = $urandom_range(0, 255);
      n = $urandom_range(1, 6);
      wrote = 0; ills = 0; ended = 1'b0;
      d0 = done_cnt; i0 = ill_cnt;
      do_start(base);
      for (int i = 0; i < n && !ended; i++) begin
        op = $urandom_range(0, 7);
        rs = $urandom_range(0, 15);
        rt = $urandom_range(0, 15);
        fn = $urandom_range(0, 5);
        imm = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 15) - 8) & 12'hFFF)
                                          : $urandom_range(0, 4095);
        last = (i == n - 1);
        send(op, rs, rt, fn, imm, last);
        if (ref_legal(op, fn, imm)) begin
          exp.push_back({8'((base + wrote) % 256), 16'(ref_word(op, rs, rt, fn, imm))});
          wrote++;
          if (last || wrote == DEPTH) ended = 1'b1;
        end else begin
          ills++;
          if (last) ended = 1'b1;
        end
      end
      wait_idle("random");
      bad = (wq.size() != exp.size());
      for (int k = 0; k < exp.size() && !bad; k++) if (wq[k] !== exp[k]) bad = 1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL random_writes: prog %0d got %0d writes want %0d", p, wq.size(), exp.size());
      end
      checks++;
      if (count !== 9'(wrote) || err !== (ills != 0) || done_cnt != d0 + 1 || ill_cnt != i0 + ills) begin
        errors++;
        $display("FAIL random_status: prog %0d count %0d err %b done %0d ill %0d want %0d %0d 1 %0d",
                 p, count, err, done_cnt - d0, ill_cnt - i0, wrote, (ills != 0), ills);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_start(8'h40);
    send(2, 1, 2, 0, 3, 1'b0);
    checks++;
    if (imem_we !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: imem_we got %b want 1", imem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_we !== 1'b0 || busy !== 1'b0 || count !== 9'd0) begin
      errors++;
      $display("FAIL midreset: we %b busy %b count %0d want 0 0 0", imem_we, busy, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: in_ready %b busy %b want 0 0", in_ready, busy);
    end
  endtask

  task automatic test_verify;
    int d0, i0;
    d0 = done_cnt; i0 = ill_cnt;
    corrupt = 1'b1;
    do_start(8'h80);
    send(3, 5, 6, 0, 2, 1'b1);
    wait_idle("verify");
    corrupt = 1'b0;
`ifdef INSTR_ENC_VERIFY_EN
    checks++;
    if (err !== 1'b1 || ill_cnt != i0 + 1 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL verify_corrupt: err %b ill %0d done %0d want 1 1 1", err, ill_cnt - i0, done_cnt - d0);
    end
`else
    checks++;
    if (err !== 1'b0 || ill_cnt != i0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL verify_ignored: err %b ill %0d done %0d want 0 0 1", err, ill_cnt - i0, done_cnt - d0);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_directed;
    test_illegal;
    test_full;
    test_random;
    test_reset_mid;
    test_verify;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
